// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX/MEM status from the pipeline
// (master side) and PC/pipeline-register controls back from the
// controller (slave side).
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] i_id_rs1;
    logic [REG_AW-1:0] i_id_rs2;
    logic              i_id_use_rs1;
    logic              i_id_use_rs2;
    logic [REG_AW-1:0] i_ex_rd;
    logic              i_ex_memread;
    logic              i_ex_mispredict;
    logic              i_dmem_busy;

    logic              o_pc_enable;
    logic              o_pc_redirect;
    logic              o_ifid_enable;
    logic              o_idex_enable;
    logic              o_exmem_enable;
    logic              o_memwb_enable;
    logic              o_ifid_flush;
    logic              o_idex_flush;
    logic [CNT_W-1:0]  o_stall_cnt;
    logic [CNT_W-1:0]  o_flush_cnt;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        output i_ex_rd, i_ex_memread, i_ex_mispredict, i_dmem_busy,
        input  o_pc_enable, o_pc_redirect,
        input  o_ifid_enable, o_idex_enable, o_exmem_enable, o_memwb_enable,
        input  o_ifid_flush, o_idex_flush,
        input  o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        input  i_ex_rd, i_ex_memread, i_ex_mispredict, i_dmem_busy,
        output o_pc_enable, o_pc_redirect,
        output o_ifid_enable, o_idex_enable, o_exmem_enable, o_memwb_enable,
        output o_ifid_flush, o_idex_flush,
        output o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage forwarding, always-taken
// pipeline. Resolves memory wait states, EX-stage branch mispredicts and
// load-use hazards, in that priority. A mispredict seen during a memory
// wait is remembered in 'pend' and applied on the first non-busy cycle.
// Optional: define HAZARD_PERF_CNT_EN to build saturating stall/flush
// performance counters; otherwise both counter outputs are tied to 0.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state;
    logic              pend;

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              busy;
    logic              lu;
    logic              mp;

    logic              pc_enable;
    logic              pc_redirect;
    logic              ifid_enable;
    logic              idex_enable;
    logic              exmem_enable;
    logic              memwb_enable;
    logic              ifid_flush;
    logic              idex_flush;

    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    assign id_rs1 = hz.i_id_rs1;
    assign id_rs2 = hz.i_id_rs2;
    assign ex_rd  = hz.i_ex_rd;
    assign busy   = hz.i_dmem_busy;

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    assign lu = hz.i_ex_memread && (ex_rd != '0) &&
                ((hz.i_id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (hz.i_id_use_rs2 && (id_rs2 == ex_rd)));

    // pend can only be set on entry to MEM_WAIT, so qualifying it with the
    // state is equivalent and keeps the held correction tied to the freeze.
    assign mp = hz.i_ex_mispredict || (pend && (state == MEM_WAIT));

    // Per-cycle control decode: memory wait > mispredict > load-use > normal;
    // everything is forced low while reset is asserted.
    always_comb begin
        pc_enable    = 1'b0;
        pc_redirect  = 1'b0;
        ifid_enable  = 1'b0;
        idex_enable  = 1'b0;
        exmem_enable = 1'b0;
        memwb_enable = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        if (i_rst_n && !busy) begin
            if (mp) begin
                pc_enable    = 1'b1;
                pc_redirect  = 1'b1;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
            end else if (lu) begin
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                idex_flush   = 1'b1;
            end else begin
                pc_enable    = 1'b1;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
            end
        end
    end

    // State and pending-mispredict tracking across memory wait states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            pend  <= 1'b0;
        end else if (busy) begin
            state <= MEM_WAIT;
            if (hz.i_ex_mispredict) begin
                pend <= 1'b1;
            end
        end else begin
            state <= RUN;
            pend  <= 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counters: stalled-PC cycles and applied mispredict flushes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_enable && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign hz.o_pc_enable    = pc_enable;
    assign hz.o_pc_redirect  = pc_redirect;
    assign hz.o_ifid_enable  = ifid_enable;
    assign hz.o_idex_enable  = idex_enable;
    assign hz.o_exmem_enable = exmem_enable;
    assign hz.o_memwb_enable = memwb_enable;
    assign hz.o_ifid_flush   = ifid_flush;
    assign hz.o_idex_flush   = idex_flush;
    assign hz.o_stall_cnt    = stall_cnt;
    assign hz.o_flush_cnt    = flush_cnt;

endmodule
